// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix-up in a final cycle.
//
// state | meaning
// IDLE  | accept start or mthi/mtlo moves; divide-by-zero is reported from here
// RUN   | one multiply or divide step per cycle, count 0..WIDTH-1
// FIX   | sign correction, HI/LO write, done pulse
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [CW-1:0]      count;

  logic               op_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op_signed = ~op[0];
  assign a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
  assign b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;

  // Multiply: opa is the multiplicand, opb the multiplier shifting out LSB-first;
  // the product builds in acc's upper half while the lower half shifts right.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);

  // Divide: opa is the dividend shifting out MSB-first, quotient bits enter acc's low half.
  assign div_shift = {rem[WIDTH-1:0], opa[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  assign prod_fix  = neg_res ? -acc : acc;
  assign quot_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix   = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      HI          <= '0;
      LO          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      count       <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      acc         <= '0;
      rem         <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op[1] && (B == '0)) begin
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              is_div  <= op[1];
              opa     <= a_mag;
              opb     <= b_mag;
              neg_res <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_rem <= op_signed & A[WIDTH-1];
              acc     <= '0;
              rem     <= '0;
              count   <= '0;
              busy    <= 1'b1;
              state   <= RUN;
            end
          end else begin
            if (mthi) HI <= A;
            if (mtlo) LO <= A;
          end
        end
        RUN: begin
          if (is_div) begin
            // A borrow out of the trial subtract restores the shifted remainder.
            rem            <= div_diff[WIDTH] ? div_shift : div_diff;
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_diff[WIDTH]};
            opa            <= opa << 1;
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            opb <= opb >> 1;
          end
          if (count == CW'(WIDTH - 1)) state <= FIX;
          else                         count <= count + CW'(1);
        end
        FIX: begin
          if (is_div) begin
            HI <= rem_fix;
            LO <= quot_fix;
          end else begin
            HI <= prod_fix[2*WIDTH-1:WIDTH];
            LO <= prod_fix[WIDTH-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a transaction-level HI/LO model checked every cycle,
// plus directed operations with hand-computed results.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(clk), .RST_N(rst_n), .start(start), .op(op), .A(a), .B(b),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done),
    .div_by_zero(dbz), .HI(hi), .LO(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural result {HI, LO} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
    logic signed [63:0] sx, sy, sq, sr;
    logic [63:0]        ux, uy, uq, ur;
    sx = 64'(signed'(x));
    sy = 64'(signed'(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00:   return sx * sy;
      2'b01:   return ux * uy;
      2'b10: begin
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  logic        model_valid = 1'b0;
  logic        m_busy, m_done, m_dbz;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left;

  // Operation latency model: accept edge loads 33, result lands when it reaches 0.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_valid = 1'b1;
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (model_valid) begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_pend;
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        if (op[1] && b == 32'd0) begin
          m_done = 1'b1;
          m_dbz  = 1'b1;
        end else begin
          m_pend = model_result(op, a, b);
          m_left = 33;
          m_busy = 1'b1;
        end
      end else begin
        if (mthi) m_hi = a;
        if (mtlo) m_lo = a;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("cyc_busy", busy, m_busy);
      chk("cyc_done", done, m_done);
      chk("cyc_dbz",  dbz,  m_dbz);
      chk("cyc_hi",   hi,   m_hi);
      chk("cyc_lo",   lo,   m_lo);
    end
  end

  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input int exp_busy, input logic exp_dbz);
    int   nb;
    logic got;
    logic dbz_seen;
    nb = 0; got = 1'b0; dbz_seen = 1'b0;
    @(posedge clk); #2;
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #2;
    start = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        dbz_seen = dbz;
      end else if (busy) nb++;
    end
    chk({name, "_done_seen"}, got, 1'b1);
    chk({name, "_busy_cycles"}, nb, exp_busy);
    chk({name, "_dbz"}, dbz_seen, exp_dbz);
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, done, 1'b0);
  endtask

  task automatic wait_done(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk({name, "_done_seen"}, got, 1'b1);
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);

    do_op("mult_m3x5",   2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 1'b0);
    do_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
    do_op("mult_m1xm1",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         33, 1'b0);
    do_op("div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
    do_op("divu_7_2",    2'b11, 32'd7,         32'd2,        32'd1,         32'd3,         33, 1'b0);
    do_op("div_min_m1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33, 1'b0);
    do_op("div_100_m7",  2'b10, 32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 33, 1'b0);

    // Simultaneous moves both write.
    @(posedge clk); #2 mthi = 1'b1; mtlo = 1'b1; a = 32'hAAAA;
    @(posedge clk); #2 mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk);
    chk("mv_both_hi", hi, 32'hAAAA);
    chk("mv_both_lo", lo, 32'hAAAA);

    @(posedge clk); #2 mthi = 1'b1; a = 32'h1234;
    @(posedge clk); #2 mthi = 1'b0; mtlo = 1'b1; a = 32'h5678;
    @(posedge clk); #2 mtlo = 1'b0;
    @(negedge clk);
    chk("preload_hi", hi, 32'h1234);
    chk("preload_lo", lo, 32'h5678);
    do_op("divu_by0",    2'b11, 32'd9,         32'd0,        32'h1234,      32'h5678,      0,  1'b1);

    // start held for 10 edges, mtlo at accept and mthi mid-run both dropped.
    @(posedge clk); #2;
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4; mtlo = 1'b1;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #2;
      mtlo = 1'b0;
      mthi = (i == 5);
      if (i == 5) a = 32'hDEAD;
    end
    @(posedge clk); #2 start = 1'b0; mthi = 1'b0;
    wait_done("hold_start");
    chk("hold_start_hi", hi, 32'h0);
    chk("hold_start_lo", lo, 32'd12);

    // Reset mid-operation.
    @(posedge clk); #2 start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd7;
    @(posedge clk); #2 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    do_op("mult_2x3",    2'b00, 32'd2,         32'd3,        32'h0,         32'd6,         33, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit owning the architectural HI/LO registers. It sits beside the ALU in the execute stage and executes mult, multu, div, divu, mthi and mtlo. Results are produced over 33 cycles instead of one combinational pass. Decode stalls on `busy`; mfhi/mflo read `HI`/`LO` directly.

## Interface
Parameters:
- `WIDTH`, 32, operand/HI/LO width; iteration count equals `WIDTH`.

Ports:
- `CLK`  in  1  clock, rising edge.
- `RST_N`  in  1  reset; one clock; reset is synchronous and active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with `start`.
- `A`  in  WIDTH  multiplicand/dividend; also mthi/mtlo write data.
- `B`  in  WIDTH  multiplier/divisor.
- `mthi`  in  1  write `A` to HI (IDLE only).
- `mtlo`  in  1  write `A` to LO (IDLE only).
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO have been updated, or the op was aborted by divide-by-zero.
- `div_by_zero`  out  1  one-cycle pulse, coincident with `done`, for div/divu with B==0.
- `HI`  out  WIDTH  high product / remainder.
- `LO`  out  WIDTH  low product / quotient.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1:
  - Latch `op`.
  - Signed ops latch |A|, |B| and a sign flag; unsigned ops latch raw values.
  - Clear the 64-bit accumulator, load count=0, go to RUN.
- IDLE, `start`=1, div/divu, B==0:
  - Stay in IDLE; pulse `done` and `div_by_zero` next cycle.
  - HI/LO are unchanged.
- Multiply, RUN: shift-add, LSB-first over the multiplier. One bit per cycle, `WIDTH` cycles, 2·WIDTH-bit product.
- Divide, RUN: restoring division, one quotient bit per cycle, MSB-first. Trial subtract of the divisor from the partial remainder.
- RUN exits to FIX when count==WIDTH-1.
- FIX:
  - Apply sign correction.
  - mult: negate the 64-bit product if the operand signs differ.
  - div: negate the quotient if signs differ; the remainder takes the dividend's sign (truncating division).
  - Write HI/LO, pulse `done`, return to IDLE.
- div of 0x80000000 by 0xFFFFFFFF yields LO=0x80000000, HI=0. No trap.
- mthi/mtlo in IDLE with `start`=0: write HI/LO at the next edge. Both may assert together and both write.
- `start` and mthi/mtlo together in IDLE: `start` wins; the move is dropped.
- `start`, mthi and mtlo are ignored while `busy`=1. The issuing stage stalls.
- HI/LO hold their value throughout RUN. They change only at the FIX edge or on an IDLE move.

## Timing
- Reset (RST_N=0 at an edge): state IDLE, HI=0, LO=0, busy=0, done=0, div_by_zero=0, count=0.
- Reset mid-operation aborts the operation; no `done` is issued.
- Accept edge E0. RUN spans edges E1..E32 (count 0..31). FIX edge is E33.
- `busy` is 1 in the cycles after E0 through E33.
- After E33: `busy`=0, `done`=1 for one cycle, HI/LO hold the new values.
- Latency is 33 cycles from accept to result. A new `start` is accepted at E34, back-to-back.
- Divide-by-zero: `done`=`div_by_zero`=1 in the cycle after E0; `busy` never rises.
- `busy` is a registered output, not combinational from `start`.
- Decode must not sample HI/LO for mfhi/mflo while `busy`=1.
- Widths:
  - Accumulator 2·WIDTH.
  - Partial remainder WIDTH+1 bits, so the trial subtraction has a borrow bit.
  - Count is ceil(log2(WIDTH)) bits and saturates at WIDTH-1.

## Test plan
- mult A=0xFFFFFFFD (-3), B=5 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; `done` high exactly one cycle; `busy` high 33 cycles.
- multu A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Repeat as signed mult -> HI=0, LO=1.
- div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1. div 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload mthi A=0x1234, mtlo A=0x5678; then divu B=0 -> `done` and `div_by_zero` pulse one cycle after accept; `busy` stays 0; HI=0x1234, LO=0x5678 unchanged.
- Launch mult 3*4 with `start` held high for 10 cycles and mthi pulsed at cycle 5 -> only one operation runs; HI=0, LO=12; the mthi is ignored.
- Start mult, drop RST_N at cycle 10 for one edge -> busy=0, HI=LO=0, no `done`. A subsequent mult 2*3 completes normally: LO=6 after 33 cycles.
